// File: rtl/pwm_duty_decoder.sv
// Recovers the duty code from an incoming PWM waveform by measuring its high time and period.
// A constant input is reported as stuck after TIMEOUT ticks without an edge.
module pwm_duty_decoder #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned PERIOD_NOM = 100,
  parameter int unsigned PERIOD_TOL = 5,
  parameter int unsigned TIMEOUT    = 200,
  parameter int unsigned TH1        = 20,
  parameter int unsigned TH2        = 55,
  parameter int unsigned TH3        = 83
) (
  input  logic             i_1Mhz_clk,
  input  logic             i_rst_n,
  input  logic             i_pwm_in,
  output logic [CNT_W-1:0] o_high_cnt,
  output logic [CNT_W-1:0] o_period,
  output logic [1:0]       o_duty_code,
  output logic             o_valid,
  output logic             o_period_err,
  output logic             o_stuck
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  localparam logic [CNT_W-1:0] CntMax   = '1;
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [CNT_W-1:0] PerMin   = CNT_W'(PERIOD_NOM - PERIOD_TOL);
  localparam logic [CNT_W-1:0] PerMax   = CNT_W'(PERIOD_NOM + PERIOD_TOL);
  localparam logic [CNT_W-1:0] IdleLast = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] Th1      = CNT_W'(TH1);
  localparam logic [CNT_W-1:0] Th2      = CNT_W'(TH2);
  localparam logic [CNT_W-1:0] Th3      = CNT_W'(TH3);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CntMax) ? v : v + CntOne;
  endfunction

  function automatic logic [1:0] duty_code(input logic [CNT_W-1:0] h);
    if (h < Th1)      return 2'd0;
    else if (h < Th2) return 2'd1;
    else if (h < Th3) return 2'd2;
    else              return 2'd3;
  endfunction

  logic             sync_q, s_q, s_dly_q;
  logic             rise, fall, edge_det, timeout;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic [CNT_W-1:0] out_high_q, out_high_d;
  logic [CNT_W-1:0] out_period_q, out_period_d;
  logic [1:0]       out_code_q, out_code_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             stuck_q, stuck_d;

  assign rise     = s_q & ~s_dly_q;
  assign fall     = ~s_q & s_dly_q;
  assign edge_det = rise | fall;
  assign timeout  = ~edge_det && (idle_q == IdleLast);

  always_ff @(posedge i_1Mhz_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q       <= 1'b0;
      s_q          <= 1'b0;
      s_dly_q      <= 1'b0;
      state_q      <= StIdle;
      period_q     <= '0;
      high_q       <= '0;
      idle_q       <= '0;
      out_high_q   <= '0;
      out_period_q <= '0;
      out_code_q   <= 2'd0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      sync_q       <= i_pwm_in;
      s_q          <= sync_q;
      s_dly_q      <= s_q;
      state_q      <= state_d;
      period_q     <= period_d;
      high_q       <= high_d;
      idle_q       <= idle_d;
      out_high_q   <= out_high_d;
      out_period_q <= out_period_d;
      out_code_q   <= out_code_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      stuck_q      <= stuck_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    period_d     = sat_inc(period_q);
    high_d       = high_q;
    idle_d       = idle_q + CntOne;
    out_high_d   = out_high_q;
    out_period_d = out_period_q;
    out_code_d   = out_code_q;
    valid_d      = 1'b0;
    err_d        = err_q;
    stuck_d      = stuck_q;

    // The fall cycle itself is not high time.
    if (state_q == StHigh && !fall) high_d = sat_inc(high_q);
    if (edge_det) idle_d = '0;

    if (rise) begin
      // Publish uses the counts accumulated up to this rise, then both counters restart.
      if (state_q == StLow) begin
        out_high_d   = high_q;
        out_period_d = period_q;
        out_code_d   = duty_code(high_q);
        err_d        = (period_q < PerMin) || (period_q > PerMax);
        stuck_d      = 1'b0;
        valid_d      = 1'b1;
      end
      period_d = CntOne;
      high_d   = CntOne;
      state_d  = StHigh;
    end else if (fall) begin
      if (state_q == StHigh) state_d = StLow;
    end else if (timeout) begin
      out_high_d   = s_q ? CntMax : '0;
      out_period_d = '0;
      out_code_d   = s_q ? 2'd3 : 2'd0;
      err_d        = 1'b0;
      stuck_d      = 1'b1;
      valid_d      = 1'b1;
      idle_d       = '0;
      state_d      = StIdle;
    end
  end

  assign o_high_cnt   = out_high_q;
  assign o_period     = out_period_q;
  assign o_duty_code  = out_code_q;
  assign o_valid      = valid_q;
  assign o_period_err = err_q;
  assign o_stuck      = stuck_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Bench for pwm_duty_decoder: directed and random PWM waveforms checked against an
// edge-timing model that predicts every publish (cycle and values).
module tb_pwm_duty_decoder;

  localparam int CntMax  = 255;
  localparam int Timeout = 200;
  localparam int Lat     = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwm = 1'b0;
  logic [7:0] high_cnt, period;
  logic [1:0] duty_code;
  logic       valid, period_err, stuck;

  pwm_duty_decoder #(
    .CNT_W     (8),
    .PERIOD_NOM(100),
    .PERIOD_TOL(5),
    .TIMEOUT   (200),
    .TH1       (20),
    .TH2       (55),
    .TH3       (83)
  ) dut (
    .i_1Mhz_clk  (clk),
    .i_rst_n     (rst_n),
    .i_pwm_in    (pwm),
    .o_high_cnt  (high_cnt),
    .o_period    (period),
    .o_duty_code (duty_code),
    .o_valid     (valid),
    .o_period_err(period_err),
    .o_stuck     (stuck)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  typedef struct {
    int cyc;
    int high;
    int period;
    int code;
    int err;
    int stuck;
  } exp_t;

  exp_t q[$];

  // Model state: driven level, measurement phase (0 idle, 1 high, 2 low), edge times.
  int m_level = 0;
  int m_st    = 0;
  int m_rise  = 0;
  int m_fall  = 0;
  int m_ref   = 0;

  function automatic int sat(input int v);
    return (v > CntMax) ? CntMax : v;
  endfunction

  function automatic int code_of(input int h);
    if (h < 20) return 0;
    if (h < 55) return 1;
    if (h < 83) return 2;
    return 3;
  endfunction

  task automatic push_exp(input int c, input int h, input int p, input int code,
                          input int err, input int stk);
    exp_t ne;
    ne.cyc = c; ne.high = h; ne.period = p; ne.code = code; ne.err = err; ne.stuck = stk;
    q.push_back(ne);
  endtask

  // One clock of stimulus; the model predicts what the DUT shows Lat cycles later.
  task automatic step(input int lvl);
    int h, p;
    @(posedge clk);
    #1;
    if (lvl != m_level) begin
      if (lvl != 0) begin
        if (m_st == 2) begin
          h = sat(m_fall - m_rise);
          p = sat(cyc - m_rise);
          push_exp(cyc + Lat, h, p, code_of(h), (p < 95 || p > 105) ? 1 : 0, 0);
        end
        m_rise = cyc;
        m_st   = 1;
      end else if (m_st == 1) begin
        m_fall = cyc;
        m_st   = 2;
      end
      m_ref = cyc + Lat;
    end else if (m_ref + Timeout == cyc + Lat) begin
      push_exp(cyc + Lat, m_level ? CntMax : 0, 0, m_level ? 3 : 0, 0, 1);
      m_ref = cyc + Lat;
      m_st  = 0;
    end
    m_level = lvl;
    pwm     = lvl[0];
  endtask

  task automatic pwm_periods(input int p, input int h, input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < p; i++) step((i < h) ? 1 : 0);
  endtask

  task automatic hold(input int lvl, input int n);
    for (int i = 0; i < n; i++) step(lvl);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_high"}, int'(high_cnt), 0);
    check_eq({tag, "_period"}, int'(period), 0);
    check_eq({tag, "_code"}, int'(duty_code), 0);
    check_eq({tag, "_valid"}, int'(valid), 0);
    check_eq({tag, "_err"}, int'(period_err), 0);
    check_eq({tag, "_stuck"}, int'(stuck), 0);
  endtask

  task automatic release_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_ref = cyc;
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        mon_e = q.pop_front();
        check_eq("valid", int'(valid), 1);
        if (valid) begin
          check_eq("high_cnt", int'(high_cnt), mon_e.high);
          check_eq("period", int'(period), mon_e.period);
          check_eq("duty_code", int'(duty_code), mon_e.code);
          check_eq("period_err", int'(period_err), mon_e.err);
          check_eq("stuck", int'(stuck), mon_e.stuck);
        end
      end else if (valid) begin
        check_eq("spurious_valid", int'(valid), 0);
      end
    end
  end

  initial begin
    int p, h, kind;
    #2;
    check_outputs_zero("reset");
    release_reset();

    // Nominal 40/100, then duty switches mid-stream.
    pwm_periods(100, 40, 5);
    pwm_periods(100, 70, 3);
    pwm_periods(100, 95, 3);
    pwm_periods(100, 10, 3);
    pwm_periods(100, 40, 2);

    // Stuck low then stuck high (timeout repeats), then recovery.
    hold(0, 250);
    hold(1, 450);
    pwm_periods(100, 40, 4);

    // Period tolerance boundaries.
    pwm_periods(120, 48, 3);
    pwm_periods(94, 38, 3);
    pwm_periods(105, 42, 3);
    pwm_periods(95, 38, 2);
    pwm_periods(106, 42, 2);

    // Asynchronous reset while in the high phase.
    hold(1, 20);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    pwm     = 1'b0;
    m_level = 0;
    m_st    = 0;
    q.delete();
    release_reset();
    pwm_periods(100, 70, 4);

    for (int seg = 0; seg < 25; seg++) begin
      kind = int'($urandom_range(0, 5));
      if (kind == 0) begin
        hold(int'($urandom_range(0, 1)), int'($urandom_range(150, 450)));
      end else begin
        p = int'($urandom_range(88, 130));
        h = int'($urandom_range(1, p - 1));
        pwm_periods(p, h, int'($urandom_range(2, 4)));
      end
    end

    hold(0, 260);
    repeat (5) @(negedge clk);
    #1;
    check_eq("pending_expectations", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
